uart_rx_os: RTL

Oversampling UART receiver, the parametrised successor to the baud-strobe receiver. It takes an OS_RATE× baud tick from the shared baud generator, synchronises and samples `rxd` at mid-bit, and assembles frames with configurable data width, parity mode and stop-bit count. Completed frames go out on a valid/ready port with per-frame parity/framing status and an overrun pulse. The block sits between the pad-side `rxd` and the RX FIFO or register interface.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_os_if.sv | 15 +
 rtl/uart_rx_sampler.sv | 64 ++++++
 rtl/uart_rx_os.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the oversampling UART receiver: FSM encodings,
// parity mode codes and a constant-foldable ceil(log2) helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Received-frame port: data plus per-frame status, valid/ready, overrun pulse.
// Master drives the frame, slave returns dout_rdy.
interface uart_rx_os_if #(parameter int DATA_W = 8);

  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              dout_rdy;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (output dout, dout_vld, parity_err, frame_err, overrun, input dout_rdy);
  modport slave  (input dout, dout_vld, parity_err, frame_err, overrun, output dout_rdy);

endinterface

// File: rtl/uart_rx_sampler.sv
// rxd synchroniser, oversample counter and mid-bit sample strobe; 2 clk sync latency.
// UART_RX_MAJORITY_EN: 2-of-3 vote around mid-bit, decision one tick later.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int OS_RATE = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic os_stb,
  input  logic rxd,
  input  logic cnt_clr,
  output logic rxd_s,
  output logic bit_stb,
  output logic bit_val
);

  localparam int             CW   = clog2(OS_RATE);
  localparam logic [CW-1:0]  MID  = CW'(OS_RATE / 2);
  localparam logic [CW-1:0]  LAST = CW'(OS_RATE - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_os_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], rxd};
  end

  assign rxd_s = r_sync[1];

  // Explicit wrap keeps non-power-of-two rates (e.g. 10, 12) correct.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_os_cnt <= '0;
    end else if (os_stb) begin
      if (cnt_clr || r_os_cnt == LAST) r_os_cnt <= '0;
      else                             r_os_cnt <= r_os_cnt + CW'(1);
    end
  end

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] MID_M1 = CW'(OS_RATE / 2 - 1);
  localparam logic [CW-1:0] MID_P1 = CW'(OS_RATE / 2 + 1);

  logic [1:0] r_early;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_early <= 2'b11;
    end else if (os_stb) begin
      if (r_os_cnt == MID_M1) r_early[0] <= rxd_s;
      if (r_os_cnt == MID)    r_early[1] <= rxd_s;
    end
  end

  assign bit_stb = os_stb && (r_os_cnt == MID_P1);
  assign bit_val = (r_early[0] & r_early[1]) | (r_early[0] & rxd_s) | (r_early[1] & rxd_s);
`else
  assign bit_stb = os_stb && (r_os_cnt == MID);
  assign bit_val = rxd_s;
`endif

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver; dout_vld one clk after the final stop decision tick.
// Holds a frame until accepted; a frame completing while one is pending is dropped with an overrun pulse.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int OS_RATE   = 16,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         os_stb,
  input  logic         rxd,
  output logic         busy,
  uart_rx_os_if.master rx_if
);

  localparam int BW = clog2(DATA_W + 1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic              r_armed;
  logic [DATA_W-1:0] r_shift;
  logic [BW-1:0]     r_bit_cnt;
  logic              r_stop_cnt;
  logic              r_ferr_acc;
  logic              r_perr;
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_vld;
  logic              r_parity_err;
  logic              r_frame_err;
  logic              r_overrun;
  logic              r_busy;

  logic w_rxd_s;
  logic w_bit_stb;
  logic w_bit_val;
  logic w_detect;
  logic w_last_stop;
  logic w_complete;
  logic w_ferr;
  logic w_perr;

  uart_rx_sampler #(.OS_RATE(OS_RATE)) u_sampler (
    .clk     (clk),
    .rstn    (rstn),
    .os_stb  (os_stb),
    .rxd     (rxd),
    .cnt_clr (w_detect),
    .rxd_s   (w_rxd_s),
    .bit_stb (w_bit_stb),
    .bit_val (w_bit_val)
  );

  assign w_detect    = os_stb && (r_state == ST_IDLE) && r_armed && !w_rxd_s;
  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_complete  = w_bit_stb && (r_state == ST_STOP) && w_last_stop;
  assign w_ferr      = r_ferr_acc | ~w_bit_val;
  assign w_perr      = (^r_shift) ^ w_bit_val ^ (PARITY == PARITY_ODD);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_detect) w_state_nxt = ST_START;
      ST_START:  if (w_bit_stb) w_state_nxt = w_bit_val ? ST_IDLE : ST_DATA;
      ST_DATA:   if (w_bit_stb && r_bit_cnt == BW'(DATA_W - 1))
                   w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (w_bit_stb) w_state_nxt = ST_STOP;
      ST_STOP:   if (w_complete) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_armed    <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_ferr_acc <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (os_stb && r_state == ST_IDLE && w_rxd_s) r_armed <= 1'b1;
      // A low stop bit disarms so a held break cannot start a new frame.
      if (w_complete && w_ferr) r_armed <= 1'b0;
      if (w_bit_stb) begin
        case (r_state)
          ST_START: begin
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_perr     <= 1'b0;
          end
          ST_DATA: begin
            r_shift   <= {w_bit_val, r_shift[DATA_W-1:1]};
            r_bit_cnt <= r_bit_cnt + BW'(1);
          end
          ST_PARITY: r_perr <= w_perr;
          ST_STOP: begin
            r_stop_cnt <= 1'b1;
            r_ferr_acc <= w_ferr;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (w_complete) begin
        if (!r_dout_vld || rx_if.dout_rdy) begin
          r_dout       <= r_shift;
          r_parity_err <= r_perr;
          r_frame_err  <= w_ferr;
          r_dout_vld   <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_dout_vld && rx_if.dout_rdy) begin
        r_dout_vld <= 1'b0;
      end
    end
  end

  assign busy             = r_busy;
  assign rx_if.dout       = r_dout;
  assign rx_if.dout_vld   = r_dout_vld;
  assign rx_if.parity_err = r_parity_err;
  assign rx_if.frame_err  = r_frame_err;
  assign rx_if.overrun    = r_overrun;

endmodule
